// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared definitions for the seven-segment capture block.
//               Holds the glyph patterns ({g,f,e,d,c,b,a}, active-high),
//               the queued entry layout and the pattern-to-digit decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    typedef struct packed {
        logic       err;
        logic [3:0] digit;
        logic [6:0] raw;
    } seg7_entry_t;

    localparam int SEG7_ENTRY_W = $bits(seg7_entry_t);

    // Unknown patterns are flagged and report digit 0 so consumers never
    // see a plausible-looking value for a garbage glyph.
    function automatic seg7_entry_t seg7_decode(input logic [6:0] pat);
        seg7_entry_t e;
        e.raw   = pat;
        e.err   = 1'b0;
        e.digit = 4'h0;
        case (pat)
            SEG_HEX_0: e.digit = 4'h0;
            SEG_HEX_1: e.digit = 4'h1;
            SEG_HEX_2: e.digit = 4'h2;
            SEG_HEX_3: e.digit = 4'h3;
            SEG_HEX_4: e.digit = 4'h4;
            SEG_HEX_5: e.digit = 4'h5;
            SEG_HEX_6: e.digit = 4'h6;
            SEG_HEX_7: e.digit = 4'h7;
            SEG_HEX_8: e.digit = 4'h8;
            SEG_HEX_9: e.digit = 4'h9;
            SEG_HEX_A: e.digit = 4'hA;
            SEG_HEX_B: e.digit = 4'hB;
            SEG_HEX_C: e.digit = 4'hC;
            SEG_HEX_D: e.digit = 4'hD;
            SEG_HEX_E: e.digit = 4'hE;
            SEG_HEX_F: e.digit = 4'hF;
            default:   e.err   = 1'b1;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_fifo.sv
`default_nettype none
// ============================================================================
// Module      : seg7_fifo
// Description : Show-ahead FIFO. pop_data always reflects the head entry.
//               A push into a full queue is accepted only when a pop happens
//               in the same cycle; otherwise it is ignored by the queue.
// Ports       : clk, rst_n (async active-low), push/push_data,
//               pop/pop_data, full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == C_DEPTH);
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rd_ptr];

    // Storage is cleared on reset so the head reads zero while empty.
    for (genvar i = 0; i < DEPTH; i++) begin : g_mem
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mem[i] <= '0;
            end else if (w_do_push && (r_wr_ptr == AW'(i))) begin
                r_mem[i] <= push_data;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg7_capture
// Description : Captures an asynchronous seven-segment bus, waits for a
//               pattern to hold STABLE_CYCLES synchronized cycles, decodes it
//               and queues each newly displayed digit on a valid/ready port.
// Ports       : clk, rst_n (async active-low)
//               segments[6:0]   {g,f,e,d,c,b,a} from the display driver
//               digit/digit_err/digit_raw/digit_valid, digit_ready  - queue head
//               blank           last committed pattern was all-off
//               drop_count[7:0] saturating count of digits lost to a full queue
// Parameters  : STABLE_CYCLES 2..255, FIFO_DEPTH power of two >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] segments,
    output logic [3:0] digit,
    output logic       digit_err,
    output logic [6:0] digit_raw,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       blank,
    output logic [7:0] drop_count
);

    localparam logic [7:0] C_STABLE    = 8'(STABLE_CYCLES);
    localparam logic [7:0] C_STABLE_M1 = 8'(STABLE_CYCLES - 1);

    logic [6:0]  r_s1;
    logic [6:0]  r_s2;
    logic [6:0]  r_cand;
    logic [6:0]  r_last;
    logic [7:0]  r_cnt;
    logic        r_blank;
    logic [7:0]  r_drop_count;

    logic        w_commit;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic        w_full;
    logic        w_empty;
    seg7_entry_t w_entry;
    seg7_entry_t w_head;

    // Two-flop synchronizer; individual bits may resolve on different
    // cycles, which the stability tracker absorbs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= segments;
            r_s2 <= r_s1;
        end
    end

    // Commit fires exactly once per stable run (cnt passes STABLE-1 once,
    // then saturates), and only when the pattern differs from the last one.
    assign w_commit = (r_s2 == r_cand) && (r_cnt == C_STABLE_M1) && (r_cand != r_last);
    assign w_push   = w_commit && (r_cand != SEG_BLANK);
    assign w_pop    = !w_empty && digit_ready;
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_entry  = seg7_decode(r_cand);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand  <= '0;
            r_cnt   <= '0;
            r_last  <= '0;
            r_blank <= 1'b1;
        end else begin
            if (r_s2 != r_cand) begin
                r_cand <= r_s2;
                r_cnt  <= '0;
            end else if (r_cnt < C_STABLE) begin
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_commit) begin
                r_last  <= r_cand;
                r_blank <= (r_cand == SEG_BLANK);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    seg7_fifo #(
        .WIDTH (SEG7_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_entry),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign digit       = w_head.digit;
    assign digit_err   = w_head.err;
    assign digit_raw   = w_head.raw;
    assign digit_valid = !w_empty;
    assign blank       = r_blank;
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_capture
// Description : Self-checking bench for seg7_capture. Directed stimulus pushes
//               hand-computed entries {err,digit,raw} into a scoreboard queue;
//               a monitor pops and compares on every accepted head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] segments = 7'h00;
    logic       digit_ready = 1'b0;
    logic [3:0] digit;
    logic       digit_err;
    logic [6:0] digit_raw;
    logic       digit_valid;
    logic       blank;
    logic [7:0] drop_count;

    int          nvec = 0;
    int          nerr = 0;
    logic [11:0] exp_q [$];

    seg7_capture #(
        .STABLE_CYCLES (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .segments    (segments),
        .digit       (digit),
        .digit_err   (digit_err),
        .digit_raw   (digit_raw),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .blank       (blank),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic expect_entry(input logic err, input logic [3:0] d, input logic [6:0] raw);
        exp_q.push_back({err, d, raw});
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        segments = p;
        tick(n);
    endtask

    // Monitor: every accepted head entry is checked against the scoreboard.
    always @(negedge clk) begin : mon
        logic [11:0] e;
        if (rst_n && digit_valid && digit_ready) begin
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL pop_unexpected: got %0h expected none", {digit_err, digit, digit_raw});
            end else begin
                e = exp_q.pop_front();
                if ({digit_err, digit, digit_raw} !== e) begin
                    nerr++;
                    $display("FAIL pop_entry: got %0h expected %0h", {digit_err, digit, digit_raw}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_head", {digit_err, digit, digit_raw}, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_blank", blank, 1);
        chk("rst_drop", drop_count, 0);
        rst_n = 1'b1;
        tick(1);

        // Single digit, latency 7 edges, blank falls on commit edge
        digit_ready = 1'b1;
        expect_entry(1'b0, 4'h1, 7'h06);
        segments = 7'h06;
        tick(6);
        chk("lat_valid_pre", digit_valid, 0);
        chk("lat_blank_pre", blank, 1);
        tick(1);
        chk("lat_valid", digit_valid, 1);
        chk("lat_blank", blank, 0);
        chk("lat_head", {digit_err, digit, digit_raw}, 12'h086);
        tick(1);
        chk("lat_valid_pulse", digit_valid, 0);
        tick(2);

        // Three queued digits, then consecutive drain
        digit_ready = 1'b0;
        expect_entry(1'b0, 4'h0, 7'h3F); hold(7'h3F, 10);
        expect_entry(1'b0, 4'h2, 7'h5B); hold(7'h5B, 10);
        expect_entry(1'b0, 4'h3, 7'h4F); hold(7'h4F, 10);
        chk("seq_valid", digit_valid, 1);
        digit_ready = 1'b1;
        tick(3);
        chk("seq_drained", digit_valid, 0);

        // Glitch to 77 inside a 7F hold is never reported
        expect_entry(1'b0, 4'h8, 7'h7F);
        segments = 7'h7F; tick(4);
        segments = 7'h77; tick(2);
        segments = 7'h7F; tick(10);
        chk("glitch_empty", digit_valid, 0);

        // Overflow: six glyphs into depth 4
        digit_ready = 1'b0;
        expect_entry(1'b0, 4'h4, 7'h66); hold(7'h66, 10);
        expect_entry(1'b0, 4'h5, 7'h6D); hold(7'h6D, 10);
        expect_entry(1'b0, 4'h6, 7'h7D); hold(7'h7D, 10);
        expect_entry(1'b0, 4'h7, 7'h07); hold(7'h07, 10);
        hold(7'h71, 10);
        hold(7'h5E, 10);
        chk("ovf_drop", drop_count, 2);
        chk("ovf_valid", digit_valid, 1);
        // Push into full queue coinciding with a pop is accepted
        expect_entry(1'b0, 4'hC, 7'h39);
        segments = 7'h39;
        tick(6);
        digit_ready = 1'b1;
        tick(1);
        digit_ready = 1'b0;
        chk("pp_drop", drop_count, 2);
        tick(3);
        digit_ready = 1'b1;
        tick(4);
        chk("pp_drained", digit_valid, 0);

        // Unknown glyph, blank in between, same glyph again
        expect_entry(1'b1, 4'h0, 7'h49); hold(7'h49, 10);
        hold(7'h00, 10);
        chk("blank_between", blank, 1);
        expect_entry(1'b1, 4'h0, 7'h49); hold(7'h49, 10);
        chk("blank_after", blank, 0);

        // Asynchronous reset with entries queued
        digit_ready = 1'b0;
        hold(7'h3F, 10);
        hold(7'h06, 10);
        hold(7'h5B, 10);
        chk("prerst_valid", digit_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", digit_valid, 0);
        chk("arst_drop", drop_count, 0);
        chk("arst_blank", blank, 1);
        chk("arst_head", {digit_err, digit, digit_raw}, 0);
        rst_n = 1'b1;
        // Segments still show 5B, so it is captured afresh after release
        digit_ready = 1'b1;
        expect_entry(1'b0, 4'h2, 7'h5B);
        hold(7'h5B, 10);
        tick(2);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_capture.md
# seg7_capture

Receiving end of the seven-segment output bus driven by the bitslam core. Samples the 7-bit segment pattern asynchronously to its source, waits for it to be stable, decodes it to a hex digit, and queues each newly displayed digit for a downstream consumer over a valid/ready interface. It is used in the test harness and loopback builds to turn the display stream back into a digit sequence.

## Interface
- STABLE_CYCLES, 4: consecutive synchronized cycles a pattern must hold before commit; legal range 2..255.
- FIFO_DEPTH, 4: digit queue depth; power of two, at least 2.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- segments  in  7  {g,f,e,d,c,b,a}, active-high; asynchronous to clk.
- digit  out  4  decoded hex value at queue head; 0 when digit_err.
- digit_err  out  1  head entry pattern is not one of the 16 hex glyphs.
- digit_raw  out  7  raw committed pattern at queue head.
- digit_valid  out  1  queue non-empty.
- digit_ready  in  1  consumer accepts head on a cycle with digit_valid high.
- blank  out  1  last committed pattern was all-off.
- drop_count  out  8  committed digits lost to a full queue; saturates at 255.

## Operation
- Reset values: digit 0, digit_err 0, digit_raw 0, digit_valid 0, blank 1, drop_count 0; sync flops, candidate and last-committed pattern all 7'h00; stability counter 0; queue empty.
- Synchronizer: two flops per segment bit; s2 is the synchronized pattern.
- Stability tracker: if s2 != candidate, candidate <= s2 and cnt <= 0. Otherwise, if cnt < STABLE_CYCLES, cnt increments. A commit fires on the edge where s2 == candidate and cnt == STABLE_CYCLES-1. Once cnt saturates at STABLE_CYCLES, no further commits occur until the pattern changes.
- Commit: skipped entirely if candidate == last-committed. Otherwise last <= candidate.
  - Candidate 7'h00: blank <= 1; nothing is queued.
  - Any other candidate: blank <= 0; push entry {err, digit, raw}.
- Decode map:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Any other nonzero pattern: err=1, digit=0.
- The same digit twice in a row is reported only if a different pattern (blank or another glyph) is committed in between.
- Queue: show-ahead FIFO; head outputs come straight from storage.
  - A pop occurs when digit_valid && digit_ready.
  - A push into a full queue is dropped and drop_count increments (saturating), unless a pop happens in the same cycle. In that case the push is accepted and there is no drop.
- A glitch shorter than STABLE_CYCLES synchronized cycles never commits; it only restarts the counter.
- rst_n assertion at any time clears all state asynchronously, including queued entries. There is no partial drain.

## Timing
- Latency: new pattern applied and held, queue empty → digit_valid rises after edge 3+STABLE_CYCLES, counted from the first edge that samples the new pattern. That is 7 edges at the default.
- blank updates on the same commit edge.
- Head outputs change on the edge after a pop. Back-to-back pops run at one entry per cycle.
- digit_valid deasserts on the pop edge that empties the queue.
- rst_n deassertion is synchronized internally by the design-wide reset scheme. The block takes no action on the first edge after release beyond normal sampling.

## Structure
- Package seg7_pkg holds:
  - the 16 SEG_HEX_* pattern constants and SEG_BLANK;
  - the seg7_entry_t typedef {err, digit[3:0], raw[6:0]};
  - a pure seg7_decode function returning seg7_entry_t.
- Sub-module seg7_fifo: parameterized width/depth, show-ahead, push/pop/full/empty, with the simultaneous push+pop-when-full rule inside it.
- Top level holds the synchronizer, stability tracker, commit logic and drop counter.

## Test plan
- Hold 7'h06 after reset, ready=1 → digit_valid pulses for one cycle with digit=1, err=0, raw=06, 7 edges after first sample. blank goes 1→0 on the same edge.
- Sequence 3F,5B,4F (each held 10 cycles), ready=0 → three entries 0,2,3 in order. Then ready=1 drains them on consecutive cycles.
- 7'h7F held 10 cycles with a 2-cycle glitch to 7'h77 mid-hold → exactly one entry, digit 8. The glitch is not reported.
- Six distinct glyphs, ready=0, depth 4 → four entries held, drop_count=2. Then the same-cycle full push+pop case → accepted, drop_count unchanged.
- 7'h49 held → digit_err=1, digit=0, raw=49. Then 00 followed by 49 again → second entry queued, blank high between.
- rst_n low for one cycle with 3 entries queued → digit_valid=0, drop_count=0, blank=1 immediately, with no clock edge needed.
